// File: rtl/bist_signature_analyzer.sv
// BIST output response analyzer: folds CUT responses into a Galois MISR and
// compares the final signature against a golden value.
module bist_signature_analyzer #(
  parameter int                WIDTH        = 3,
  parameter int                SIG_W        = 4,
  parameter logic [SIG_W-1:0]  POLY         = 4'h3,
  parameter logic [SIG_W-1:0]  SEED         = 4'h0,
  parameter int                NUM_PATTERNS = 7,
  parameter logic [SIG_W-1:0]  GOLDEN       = 4'hC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_in,
  output logic [SIG_W-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPRESS,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] misr_q, misr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  // One Galois MISR step: shift, fold the tap polynomial on carry-out, XOR input.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                 input logic [WIDTH-1:0] resp);
    logic [SIG_W-1:0] fb_mask;
    fb_mask = cur[SIG_W-1] ? POLY : '0;
    return (cur << 1) ^ fb_mask ^ SIG_W'(resp);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      misr_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      misr_q  <= misr_d;
      count_q <= count_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    misr_d  = misr_q;
    count_d = count_q;
    done_d  = done_q;
    pass_d  = pass_q;
    // Abort overrides everything, including a simultaneous start; MISR is left as-is.
    if (abort) begin
      state_d = S_IDLE;
      count_d = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_d = S_LOAD;
        end
        S_LOAD: begin
          misr_d  = SEED;
          count_d = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = S_COMPRESS;
        end
        S_COMPRESS: begin
          if (resp_valid) begin
            misr_d  = misr_step(misr_q, resp_in);
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_IDX) state_d = S_COMPARE;
          end
        end
        S_COMPARE: begin
          pass_d  = (misr_q == GOLDEN);
          done_d  = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          // Clear the result on restart so done never overlaps busy.
          if (start) begin
            state_d = S_LOAD;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign signature = misr_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_COMPRESS) || (state_q == S_COMPARE);
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed bench for bist_signature_analyzer with default parameters.
module tb_bist_signature_analyzer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       resp_valid = 1'b0;
  logic [2:0] resp_in = 3'b000;
  logic [3:0] signature;
  logic       busy, done, pass;

  int nchk  = 0;
  int nfail = 0;

  bist_signature_analyzer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .resp_valid(resp_valid),
    .resp_in   (resp_in),
    .signature (signature),
    .busy      (busy),
    .done      (done),
    .pass      (pass)
  );

  always #5 clock = ~clock;

  // Reference MISR: x^4+x+1 Galois form, 3-bit input zero-extended.
  function automatic logic [3:0] model_step(input logic [3:0] s, input logic [2:0] r);
    logic [3:0] n;
    n = {s[2:0], 1'b0};
    if (s[3]) n = n ^ 4'h3;
    n = n ^ {1'b0, r};
    return n;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic absorb(input logic [2:0] r);
    resp_valid = 1'b1;
    resp_in    = r;
    tick();
    resp_valid = 1'b0;
    resp_in    = 3'b000;
  endtask

  task automatic golden_absorbs();
    absorb(3'b001);
    for (int i = 0; i < 6; i++) absorb(3'b000);
  endtask

  task automatic test_reset();
    #12;
    nchk++; if (signature !== 4'h0) begin nfail++; $display("FAIL rst_sig: got %h expected 0", signature); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    nchk++; if (done !== 1'b0) begin nfail++; $display("FAIL rst_done: got %b expected 0", done); end
    nchk++; if (pass !== 1'b0) begin nfail++; $display("FAIL rst_pass: got %b expected 0", pass); end
    @(posedge clock);
    #1 reset = 1'b1;
    tick();
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_golden();
    logic [3:0] exp;
    logic [2:0] r;
    exp = 4'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    nchk++; if (busy !== 1'b1) begin nfail++; $display("FAIL t2_busy_load: got %b expected 1", busy); end
    tick();
    for (int i = 0; i < 7; i++) begin
      r   = (i == 0) ? 3'b001 : 3'b000;
      exp = model_step(exp, r);
      absorb(r);
      nchk++; if (signature !== exp) begin nfail++; $display("FAIL t2_sig%0d: got %h expected %h", i, signature, exp); end
    end
    nchk++; if (done !== 1'b0) begin nfail++; $display("FAIL t2_done_early: got %b expected 0", done); end
    tick();
    nchk++; if (signature !== 4'hC) begin nfail++; $display("FAIL t2_final: got %h expected c", signature); end
    nchk++; if (done !== 1'b1) begin nfail++; $display("FAIL t2_done: got %b expected 1", done); end
    nchk++; if (pass !== 1'b1) begin nfail++; $display("FAIL t2_pass: got %b expected 1", pass); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL t2_busy_done: got %b expected 0", busy); end
  endtask

  task automatic test_mismatch();
    logic [3:0] exp;
    logic [2:0] r;
    exp = 4'h0;
    do_start();
    for (int i = 0; i < 7; i++) begin
      r   = (i == 0) ? 3'b010 : 3'b000;
      exp = model_step(exp, r);
      absorb(r);
    end
    tick();
    nchk++; if (signature !== exp) begin nfail++; $display("FAIL t3_final: got %h expected %h", signature, exp); end
    nchk++; if (done !== 1'b1) begin nfail++; $display("FAIL t3_done: got %b expected 1", done); end
    nchk++; if (pass !== (exp == 4'hC)) begin nfail++; $display("FAIL t3_pass: got %b expected %b", pass, exp == 4'hC); end
  endtask

  task automatic test_gaps();
    logic [3:0] exp;
    exp = 4'h0;
    do_start();
    absorb(3'b001); exp = model_step(exp, 3'b001);
    absorb(3'b000); exp = model_step(exp, 3'b000);
    absorb(3'b000); exp = model_step(exp, 3'b000);
    for (int g = 0; g < 3; g++) begin
      resp_in = 3'b111;
      start   = (g == 1);
      tick();
      start   = 1'b0;
      nchk++; if (signature !== exp) begin nfail++; $display("FAIL t4_hold%0d: got %h expected %h", g, signature, exp); end
      nchk++; if (busy !== 1'b1) begin nfail++; $display("FAIL t4_busy%0d: got %b expected 1", g, busy); end
    end
    resp_in = 3'b000;
    for (int i = 0; i < 4; i++) absorb(3'b000);
    nchk++; if (busy !== 1'b1) begin nfail++; $display("FAIL t4_busy_cmp: got %b expected 1", busy); end
    tick();
    nchk++; if (signature !== 4'hC) begin nfail++; $display("FAIL t4_final: got %h expected c", signature); end
    nchk++; if (pass !== 1'b1 || done !== 1'b1) begin nfail++; $display("FAIL t4_result: got done=%b pass=%b expected 1 1", done, pass); end
  endtask

  task automatic test_abort();
    do_start();
    absorb(3'b001);
    absorb(3'b000);
    absorb(3'b000);
    resp_valid = 1'b1;
    resp_in    = 3'b000;
    abort      = 1'b1;
    tick();
    abort      = 1'b0;
    resp_valid = 1'b0;
    nchk++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin nfail++; $display("FAIL t5_abort: got busy=%b done=%b pass=%b expected 0 0 0", busy, done, pass); end
    nchk++; if (signature !== 4'h4) begin nfail++; $display("FAIL t5_misr_hold: got %h expected 4", signature); end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL t5_start_abort: got busy=%b expected 0", busy); end
    tick();
    nchk++; if (busy !== 1'b0 || done !== 1'b0) begin nfail++; $display("FAIL t5_still_idle: got busy=%b done=%b expected 0 0", busy, done); end
    do_start();
    golden_absorbs();
    tick();
    nchk++; if (done !== 1'b1 || pass !== 1'b1) begin nfail++; $display("FAIL t5_rerun: got done=%b pass=%b expected 1 1", done, pass); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    nchk++; if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL t5_abort_done: got busy=%b done=%b pass=%b expected 0 0 0", busy, done, pass); end
    nchk++; if (signature !== 4'hC) begin nfail++; $display("FAIL t5_abort_done_sig: got %h expected c", signature); end
  endtask

  task automatic test_restart_from_done();
    do_start();
    golden_absorbs();
    tick();
    resp_valid = 1'b1;
    resp_in    = 3'b101;
    tick();
    tick();
    resp_valid = 1'b0;
    resp_in    = 3'b000;
    nchk++; if (signature !== 4'hC) begin nfail++; $display("FAIL t6_done_hold: got %h expected c", signature); end
    nchk++; if (done !== 1'b1 || pass !== 1'b1) begin nfail++; $display("FAIL t6_done_flags: got done=%b pass=%b expected 1 1", done, pass); end
    start = 1'b1;
    tick();
    start = 1'b0;
    nchk++; if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1) begin nfail++; $display("FAIL t6_restart: got busy=%b done=%b pass=%b expected 1 0 0", busy, done, pass); end
    tick();
    nchk++; if (signature !== 4'h0) begin nfail++; $display("FAIL t6_seed: got %h expected 0", signature); end
    golden_absorbs();
    tick();
    nchk++; if (done !== 1'b1 || pass !== 1'b1) begin nfail++; $display("FAIL t6_rerun: got done=%b pass=%b expected 1 1", done, pass); end
  endtask

  task automatic test_reset_midrun();
    do_start();
    absorb(3'b001);
    absorb(3'b000);
    absorb(3'b000);
    #2 reset = 1'b0;
    #1;
    nchk++; if (signature !== 4'h0) begin nfail++; $display("FAIL t1_sig: got %h expected 0", signature); end
    nchk++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin nfail++; $display("FAIL t1_flags: got busy=%b done=%b pass=%b expected 0 0 0", busy, done, pass); end
    @(posedge clock);
    #1 reset = 1'b1;
    tick();
    nchk++; if (busy !== 1'b0 || signature !== 4'h0) begin nfail++; $display("FAIL t1_after: got busy=%b sig=%h expected 0 0", busy, signature); end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_mismatch();
    test_gaps();
    test_abort();
    test_restart_from_done();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
